// File: rtl/display_source_arbiter.sv
// ---------------------------------------------------------------------------
// display_source_arbiter
//
// Chooses one of NUM_SRC OLED / seven-segment source channels for the shared
// display pins. A source switch only takes effect on a rising edge of the
// OLED frame_begin strobe, so a frame never mixes two sources. Optionally
// BLANK_FRAMES whole blank frames are shown between the old and new source.
// Requests naming a channel that does not exist are rejected and flagged.
// Single clock domain (clk_6p25M).
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   frame_begin  in   frame-start strobe (rising edge detected here)
//   sel_req      in   requested source index
//   sel_valid    in   request qualifier
//   sel_ready    out  high while a request can be accepted
//   oled_in      in   packed pixel data, source i at [i*PIX_W +: PIX_W]
//   an_in        in   packed anode data, source i at [i*4 +: 4]
//   seg_in       in   packed segment data, source i at [i*8 +: 8]
//   oled_data    out  registered pixel data to the OLED
//   an           out  registered anode drive (active-low)
//   seg          out  registered segment drive (active-low)
//   active_sel   out  source currently driving the outputs
//   switching    out  high from accepting a switch until it commits
//   err_bad_sel  out  one-cycle pulse after an out-of-range request
// ---------------------------------------------------------------------------
module display_source_arbiter #(
    parameter int               NUM_SRC      = 8,
    parameter int               SEL_W        = 4,
    parameter int               PIX_W        = 16,
    parameter int               BLANK_FRAMES = 2,
    parameter logic [PIX_W-1:0] BLANK_COLOR  = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_begin,
    input  logic [SEL_W-1:0]         sel_req,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    input  logic [NUM_SRC*PIX_W-1:0] oled_in,
    input  logic [NUM_SRC*4-1:0]     an_in,
    input  logic [NUM_SRC*8-1:0]     seg_in,
    output logic [PIX_W-1:0]         oled_data,
    output logic [3:0]               an,
    output logic [7:0]               seg,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     switching,
    output logic                     err_bad_sel
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_BLANK      = 2'd2
    } state_e;

    // Compare in SEL_W+1 bits so NUM_SRC == 2**SEL_W is representable.
    localparam logic [SEL_W:0] NUM_SRC_L      = (SEL_W+1)'(NUM_SRC);
    localparam logic [3:0]     BLANK_CNT_INIT = 4'(BLANK_FRAMES);
    localparam bit             NO_BLANK       = (BLANK_FRAMES == 0);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   active_sel_q, active_sel_d;
    logic [SEL_W-1:0]   pending_q, pending_d;
    logic [3:0]         blank_cnt_q, blank_cnt_d;
    logic               err_q, err_d;
    logic               frame_begin_q;
    logic [PIX_W-1:0]   oled_q, oled_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;

    logic               frame_edge_s;
    logic               accept_s;
    logic               req_in_range_s;

    // A strobe held high for several cycles counts as a single frame edge.
    assign frame_edge_s   = frame_begin & ~frame_begin_q;
    assign sel_ready      = (state_q == ST_IDLE);
    assign switching      = (state_q != ST_IDLE);
    assign accept_s       = sel_valid & sel_ready;
    assign req_in_range_s = ({1'b0, sel_req} < NUM_SRC_L);

    // Frame-begin history register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_begin_q <= 1'b0;
        end else begin
            frame_begin_q <= frame_begin;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            active_sel_q <= {SEL_W{1'b0}};
            pending_q    <= {SEL_W{1'b0}};
            blank_cnt_q  <= 4'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            pending_q    <= pending_d;
            blank_cnt_q  <= blank_cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic: accept requests in IDLE, commit on frame edges.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        pending_d    = pending_q;
        blank_cnt_d  = blank_cnt_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!req_in_range_s) begin
                        err_d = 1'b1;
                    end else if (sel_req == active_sel_q) begin
                        // Re-selecting the live source is a no-op.
                        state_d = ST_IDLE;
                    end else begin
                        pending_d = sel_req;
                        state_d   = ST_WAIT_FRAME;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_FRAME: begin
                if (frame_edge_s) begin
                    if (NO_BLANK) begin
                        active_sel_d = pending_q;
                        state_d      = ST_IDLE;
                    end else begin
                        blank_cnt_d = BLANK_CNT_INIT;
                        state_d     = ST_BLANK;
                    end
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end

            ST_BLANK: begin
                if (frame_edge_s) begin
                    // The count reaching zero on this edge ends the blank run.
                    if (blank_cnt_q <= 4'd1) begin
                        blank_cnt_d  = 4'd0;
                        active_sel_d = pending_q;
                        state_d      = ST_IDLE;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 4'd1;
                    end
                end else begin
                    state_d = ST_BLANK;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                blank_cnt_d = 4'd0;
            end
        endcase
    end

    // Output mux: blank while in BLANK, otherwise the live source.
    always_comb begin
        oled_d = BLANK_COLOR;
        an_d   = 4'hF;
        seg_d  = 8'hFF;
        if (state_q == ST_BLANK) begin
            oled_d = BLANK_COLOR;
            an_d   = 4'hF;
            seg_d  = 8'hFF;
        end else begin
            oled_d = oled_in[int'(active_sel_q)*PIX_W +: PIX_W];
            an_d   = an_in[int'(active_sel_q)*4 +: 4];
            seg_d  = seg_in[int'(active_sel_q)*8 +: 8];
        end
    end

    // Registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oled_q <= BLANK_COLOR;
            an_q   <= 4'hF;
            seg_q  <= 8'hFF;
        end else begin
            oled_q <= oled_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign oled_data   = oled_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign active_sel  = active_sel_q;
    assign err_bad_sel = err_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
module tb_display_source_arbiter;

    logic          clk;
    logic          rst_n;
    logic          frame_begin;
    logic [3:0]    sel_req;
    logic          sel_valid;
    logic [127:0]  oled_in_s;
    logic [31:0]   an_in_s;
    logic [63:0]   seg_in_s;

    // DUT A: 6 sources, 2 blank frames
    logic          ready_a, sw_a, err_a;
    logic [15:0]   oled_a;
    logic [3:0]    an_a, act_a;
    logic [7:0]    seg_a;
    // DUT B: 8 sources, no blank frames
    logic          ready_b, sw_b, err_b;
    logic [15:0]   oled_b;
    logic [3:0]    an_b, act_b;
    logic [7:0]    seg_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] exp_q[$];

    display_source_arbiter #(.NUM_SRC(6), .SEL_W(4), .PIX_W(16), .BLANK_FRAMES(2),
                             .BLANK_COLOR(16'h0000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin),
        .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(ready_a),
        .oled_in(oled_in_s[95:0]), .an_in(an_in_s[23:0]), .seg_in(seg_in_s[47:0]),
        .oled_data(oled_a), .an(an_a), .seg(seg_a),
        .active_sel(act_a), .switching(sw_a), .err_bad_sel(err_a));

    display_source_arbiter #(.NUM_SRC(8), .SEL_W(4), .PIX_W(16), .BLANK_FRAMES(0),
                             .BLANK_COLOR(16'h0000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin),
        .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(ready_b),
        .oled_in(oled_in_s), .an_in(an_in_s), .seg_in(seg_in_s),
        .oled_data(oled_b), .an(an_b), .seg(seg_b),
        .active_sel(act_b), .switching(sw_b), .err_bad_sel(err_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) begin
            oled_in_s[i*16 +: 16] = 16'($urandom_range(1, 65535));
            an_in_s[i*4 +: 4]     = 4'($urandom_range(0, 14));
            seg_in_s[i*8 +: 8]    = 8'($urandom_range(0, 254));
        end
    endtask

    function automatic logic [27:0] exp_ch(int i);
        return {oled_in_s[i*16 +: 16], an_in_s[i*4 +: 4], seg_in_s[i*8 +: 8]};
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        sel_valid   = 1'b0;
        sel_req     = 4'd0;
        frame_begin = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [27:0] e;
        rst_n = 1'b0; sel_valid = 1'b0; sel_req = 4'd0; frame_begin = 1'b0;
        rand_inputs();
        tick();
        n_checks++;
        if ({oled_a, an_a, seg_a, act_a, ready_a, sw_a, err_a} !== {16'h0000, 4'hF, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got %h/%h/%h sel=%0d rdy=%b sw=%b err=%b, want 0000/f/ff sel=0 rdy=1 sw=0 err=0",
                     oled_a, an_a, seg_a, act_a, ready_a, sw_a, err_a);
        end
        n_checks++;
        if ({oled_b, an_b, seg_b, act_b, ready_b} !== {16'h0000, 4'hF, 8'hFF, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_b: got %h/%h/%h sel=%0d rdy=%b", oled_b, an_b, seg_b, act_b, ready_b);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            e = exp_ch(0);
            tick();
            n_checks++;
            if ({oled_a, an_a, seg_a} !== e) begin
                n_fail++;
                $display("FAIL reset_ch0_latency: got %h, want %h", {oled_a, an_a, seg_a}, e);
            end
        end
    endtask

    task automatic test_switch_blank();
        logic [27:0] e, got;
        logic        blank;
        do_reset();
        sel_req = 4'd3;
        for (int cyc = 1; cyc <= 320; cyc++) begin
            sel_valid   = (cyc == 10);
            frame_begin = (cyc == 100) || (cyc >= 200 && cyc <= 204) || (cyc == 300);
            rand_inputs();
            blank = (cyc >= 101) && (cyc <= 300);
            exp_q.push_back(blank ? {16'h0000, 4'hF, 8'hFF} : exp_ch((cyc >= 301) ? 3 : 0));
            tick();
            e   = exp_q.pop_front();
            got = {oled_a, an_a, seg_a};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL switch_out cyc=%0d: got %h, want %h", cyc, got, e);
            end
            n_checks++;
            if (act_a !== ((cyc >= 300) ? 4'd3 : 4'd0)) begin
                n_fail++;
                $display("FAIL switch_active cyc=%0d: got %0d, want %0d", cyc, act_a, (cyc >= 300) ? 3 : 0);
            end
            n_checks++;
            if ({sw_a, ready_a} !== (((cyc >= 10) && (cyc < 300)) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL switch_flags cyc=%0d: got sw=%b rdy=%b", cyc, sw_a, ready_a);
            end
        end
        sel_valid = 1'b0; frame_begin = 1'b0;
    endtask

    task automatic test_bad_sel();
        logic [3:0] bad [2];
        bad[0] = 4'd7;
        bad[1] = 4'd6;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sel_req = bad[k]; sel_valid = 1'b1;
            tick();
            sel_valid = 1'b0;
            n_checks++;
            if ({err_a, act_a, ready_a, sw_a} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bad_sel_pulse req=%0d: got err=%b sel=%0d rdy=%b sw=%b, want 1/0/1/0",
                         bad[k], err_a, act_a, ready_a, sw_a);
            end
            tick();
            n_checks++;
            if ({err_a, act_a, ready_a} !== {1'b0, 4'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL bad_sel_clear req=%0d: got err=%b sel=%0d rdy=%b, want 0/0/1",
                         bad[k], err_a, act_a, ready_a);
            end
        end
        sel_req = 4'd5; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        n_checks++;
        if ({err_a, sw_a, ready_a} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL top_valid_sel: got err=%b sw=%b rdy=%b, want 0/1/0", err_a, sw_a, ready_a);
        end
    endtask

    task automatic test_same_and_busy();
        do_reset();
        sel_req = 4'd0; sel_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({sw_a, ready_a, err_a} !== {1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL same_source k=%0d: got sw=%b rdy=%b err=%b, want 0/1/0", k, sw_a, ready_a, err_a);
            end
        end
        // Accept on the same edge as a frame edge: must wait for the next one.
        sel_req = 4'd2; sel_valid = 1'b1; frame_begin = 1'b1;
        tick();
        sel_valid = 1'b0; frame_begin = 1'b0;
        tick();
        sel_req = 4'd4; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        n_checks++;
        if ({sw_a, ready_a, act_a} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL busy_wait: got sw=%b rdy=%b sel=%0d, want 1/0/0", sw_a, ready_a, act_a);
        end
        for (int f = 0; f < 3; f++) begin
            frame_begin = 1'b1;
            tick();
            frame_begin = 1'b0;
            n_checks++;
            if (act_a !== ((f == 2) ? 4'd2 : 4'd0)) begin
                n_fail++;
                $display("FAIL busy_commit f=%0d: got sel=%0d, want %0d", f, act_a, (f == 2) ? 2 : 0);
            end
            tick();
            tick();
        end
        n_checks++;
        if ({sw_a, ready_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL busy_done: got sw=%b rdy=%b, want 0/1", sw_a, ready_a);
        end
    endtask

    task automatic test_reset_in_blank();
        do_reset();
        oled_in_s[15:0] = 16'h1234; an_in_s[3:0] = 4'h5; seg_in_s[7:0] = 8'hA5;
        sel_req = 4'd3; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0; frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({oled_a, an_a, seg_a, sw_a} !== {16'h0000, 4'hF, 8'hFF, 1'b1}) begin
            n_fail++;
            $display("FAIL blank_output: got %h/%h/%h sw=%b, want 0000/f/ff sw=1", oled_a, an_a, seg_a, sw_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({oled_a, an_a, seg_a, act_a, sw_a, ready_a} !== {16'h0000, 4'hF, 8'hFF, 4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_in_blank: got %h/%h/%h sel=%0d sw=%b rdy=%b", oled_a, an_a, seg_a, act_a, sw_a, ready_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        tick();
        n_checks++;
        if ({act_a, oled_a, an_a, seg_a} !== {4'd0, 16'h1234, 4'h5, 8'hA5}) begin
            n_fail++;
            $display("FAIL pending_discard: got sel=%0d %h/%h/%h, want 0 1234/5/a5", act_a, oled_a, an_a, seg_a);
        end
    endtask

    task automatic test_no_blank();
        logic [27:0] e, got;
        do_reset();
        sel_req = 4'd5;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            sel_valid   = (cyc == 3);
            frame_begin = (cyc == 20);
            rand_inputs();
            exp_q.push_back(exp_ch((cyc >= 21) ? 5 : 0));
            tick();
            e   = exp_q.pop_front();
            got = {oled_b, an_b, seg_b};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL noblank_out cyc=%0d: got %h, want %h", cyc, got, e);
            end
            n_checks++;
            if ({act_b, sw_b} !== {((cyc >= 20) ? 4'd5 : 4'd0), ((cyc >= 3) && (cyc < 20))}) begin
                n_fail++;
                $display("FAIL noblank_state cyc=%0d: got sel=%0d sw=%b", cyc, act_b, sw_b);
            end
        end
        sel_valid = 1'b0; frame_begin = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sel_valid = 1'b0; sel_req = 4'd0; frame_begin = 1'b0;
        oled_in_s = '0; an_in_s = '0; seg_in_s = '0;
        test_reset();
        test_switch_blank();
        test_bad_sel();
        test_same_and_busy();
        test_reset_in_blank();
        test_no_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_source_arbiter.md
# display_source_arbiter

Parametrised successor to the fixed top-level output selector: chooses one of `NUM_SRC` OLED/seven-segment source channels for the shared display pins, driven by a select request from the state controller. Source switches are frame-aligned: a switch takes effect only on an OLED `frame_begin` edge, so a frame never mixes two sources. An optional run of blank frames is inserted between sources. Out-of-range selects are rejected and flagged. Sits between the game/menu modules and `Oled_Display`, `an` and `seg`, in the `clk_6p25M` domain.

## Interface
- `NUM_SRC`, 8: number of source channels, 2..16.
- `SEL_W`, 4: select width; must satisfy 2^`SEL_W` >= `NUM_SRC`.
- `PIX_W`, 16: OLED pixel width.
- `BLANK_FRAMES`, 2: blank frames inserted per switch, 0..15.
- `BLANK_COLOR`, 16'h0000: pixel value driven while blanking or in reset.

- `clk` in 1: pixel clock, 6.25 MHz; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_begin` in 1: frame-start strobe from `Oled_Display`; rising-edge detected internally.
- `sel_req` in `SEL_W`: requested source index.
- `sel_valid` in 1: request qualifier.
- `sel_ready` out 1: arbiter can accept a request.
- `oled_in` in `NUM_SRC`*`PIX_W`: packed pixel data; source i occupies bits [i*`PIX_W` +: `PIX_W`].
- `an_in` in `NUM_SRC`*4: packed anode inputs.
- `seg_in` in `NUM_SRC`*8: packed segment inputs.
- `oled_data` out `PIX_W`: registered pixel data to the OLED.
- `an` out 4: registered anode drive (active-low).
- `seg` out 8: registered segment drive (active-low).
- `active_sel` out `SEL_W`: source currently driving the outputs.
- `switching` out 1: high from accepting a switch until it commits.
- `err_bad_sel` out 1: one-cycle pulse when a request has `sel_req` >= `NUM_SRC`.

## Operation
- A request is accepted on any edge where `sel_valid` and `sel_ready` are both high.
- States:
  - IDLE: `sel_ready`=1.
  - WAIT_FRAME: `sel_ready`=0.
  - BLANK: `sel_ready`=0.
- IDLE, accepted `sel_req` >= `NUM_SRC`: stay in IDLE. `err_bad_sel`=1 for the next cycle only; `active_sel` does not change.
- IDLE, accepted `sel_req` == `active_sel`: stay in IDLE; no blanking, no error.
- IDLE, any other accepted request: latch `pending`=`sel_req` and go to WAIT_FRAME.
- WAIT_FRAME, on a frame edge:
  - if `BLANK_FRAMES`=0: `active_sel`<=`pending`, go to IDLE;
  - otherwise: go to BLANK with `blank_cnt`=`BLANK_FRAMES`.
- BLANK, on a frame edge: `blank_cnt` decrements. When it reaches 0 on that edge, `active_sel`<=`pending` and go to IDLE. This gives exactly `BLANK_FRAMES` full blank frames.
- Frame edge definition: `frame_begin`=1 this cycle and 0 in the previous cycle. A multi-cycle high strobe counts once.
- Output mux, registered every cycle:
  - in BLANK: `oled_data`=`BLANK_COLOR`, `an`=4'hF, `seg`=8'hFF;
  - otherwise: the channel selected by `active_sel`.
- WAIT_FRAME still shows the old source.
- `switching`=1 in WAIT_FRAME and BLANK.
- Requests arriving while `sel_ready`=0 are ignored. There is no queue.
- A `sel_valid` held high for several cycles in IDLE with an unchanged value is harmless, since it is the same as `active_sel` after the commit.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE, `active_sel`=0, `pending`=0, `blank_cnt`=0;
  - `oled_data`=`BLANK_COLOR`, `an`=4'hF, `seg`=8'hFF;
  - `sel_ready`=1, `switching`=0, `err_bad_sel`=0.
- Reset mid-switch discards the pending request.
- Source-to-output latency: 1 cycle (registered mux).
- Accept at edge k: state is WAIT_FRAME after edge k; `sel_ready` falls and `switching` rises after edge k.
- Frame edge seen at edge m: the state update happens at edge m, and outputs reflect the new mode after edge m+1. The frame's first pixel therefore sees blank or new data given `Oled_Display`'s sampling slack; this is verified at the pins.
- Commit at edge m: `sel_ready`=1 and `switching`=0 after edge m. A new request can be accepted at edge m+1.
- Accept in IDLE on the same edge as a frame edge: the request waits for the next frame edge.

## Test plan
- Reset value check:
  - drive reset low, then release;
  - outputs must be 0000 / F / FF, `active_sel`=0, `sel_ready`=1;
  - after the release, `oled_data` must equal `oled_in` channel 0 one cycle after a change.
- Switch 0->3 with `BLANK_FRAMES`=2:
  - request at cycle 10, frame edges at 100, 200, 300;
  - `active_sel` must be 0 until edge 300, then 3;
  - blank output must appear only between the frames at 100 and 300;
  - `switching` must be high for cycles 11..300.
- Bad select:
  - `NUM_SRC`=6, `sel_req`=7;
  - `err_bad_sel` must pulse for exactly 1 cycle, `active_sel` must not change, `sel_ready` must stay 1.
- Same-source and busy cases:
  - `sel_req`=`active_sel` gives no `switching` pulse;
  - a second request during WAIT_FRAME is ignored, and the first one commits.
- Strobe and reset robustness:
  - a `frame_begin` held high for 5 cycles must decrement `blank_cnt` only once;
  - `rst_n` pulled low during BLANK must give immediate reset outputs and `active_sel`=0.
- `BLANK_FRAMES`=0:
  - commit must happen on the first frame edge after the accept, with no blank cycle on `oled_data`.
